vga_sync_gen: RTL and testbench

Pixel-timing generator for the 640x480 @ 60 Hz VGA display path. It divides the board clock down to a pixel-enable strobe and runs the horizontal and vertical scan counters. It produces registered `hsync`/`vsync` and the `CounterX`/`CounterY` coordinates that drive the field/colour stage directly downstream. Every output changes only on pixel-enable edges, so each output is stable for a whole pixel period.

---
 rtl/vga_sync_gen_pkg.sv | 32 +++
 rtl/vga_axis_timer.sv | 65 ++++++
 rtl/vga_sync_gen.sv | 106 ++++++++++
 tb/tb_vga_sync_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 VGA timing defaults, derived totals and sync boundaries, and axis phase encoding.
package vga_sync_gen_pkg;
  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D      = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D      = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
  localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

  typedef enum logic [1:0] {
    PH_ACT = 2'd0,
    PH_FP  = 2'd1,
    PH_SYN = 2'd2,
    PH_BP  = 2'd3
  } phase_t;

  function automatic int axis_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction
endpackage

// File: rtl/vga_axis_timer.sv
// One scan axis: position counter plus ACT/FP/SYN/BP phase FSM with registered sync level.
// Count, phase and sync move together on i_step; o_wrap flags the step that returns the count to 0.
module vga_axis_timer
  import vga_sync_gen_pkg::*;
#(
  parameter int   ACTIVE   = H_ACTIVE_D,
  parameter int   FP       = H_FP_D,
  parameter int   SYNC     = H_SYNC_D,
  parameter int   BP       = H_BP_D,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt,
  output phase_t           o_phase,
  output logic             o_wrap,
  output logic             o_sync
);
  localparam int               TOTAL     = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYN_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BP_START  = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_count;
  phase_t           r_phase;
  logic             r_sync;
  logic             w_last;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_last      = (r_count == LAST);
  assign w_count_nxt = !i_step ? r_count : (w_last ? '0 : r_count + 1'b1);

  // Phase and sync are decided from the value the counter is about to take,
  // so they always describe the count presented on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= LAST;
      r_phase <= PH_BP;
      r_sync  <= ~SYNC_POL;
    end else if (i_step) begin
      r_count <= w_count_nxt;
      case (r_phase)
        PH_ACT: if (w_count_nxt == FP_START) r_phase <= PH_FP;
        PH_FP:  if (w_count_nxt == SYN_START) begin
                  r_phase <= PH_SYN;
                  r_sync  <= SYNC_POL;
                end
        PH_SYN: if (w_count_nxt == BP_START) begin
                  r_phase <= PH_BP;
                  r_sync  <= ~SYNC_POL;
                end
        PH_BP:  if (w_last) r_phase <= PH_ACT;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_phase     = r_phase;
  assign o_wrap      = i_step & w_last;
  assign o_sync      = r_sync;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel timing: clock divider to pixel strobe, horizontal/vertical scan counters, registered syncs.
// Outputs other than pix_en change only on pix_en edges and reflect the coordinates of that same edge.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] CounterX,
  output logic [CNT_W-1:0] CounterY,
  output logic             hsync,
  output logic             vsync,
  output logic             in_display,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_sync_gen: scan totals exceed counter range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV out of range 1..16");
    end
  endgenerate

  logic [3:0]       r_div;
  logic             r_in_display;
  logic             r_line_start;
  logic             r_frame_start;
  logic             w_pix_en;
  logic             w_v_step;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  phase_t           w_h_phase;
  phase_t           w_v_phase;

  assign w_pix_en = (r_div == 4'(CLK_DIV - 1));
  assign w_v_step = w_pix_en & w_h_wrap;

  vga_axis_timer #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h_timer (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_pix_en),
    .o_count    (CounterX),
    .o_count_nxt(w_x_nxt),
    .o_phase    (w_h_phase),
    .o_wrap     (w_h_wrap),
    .o_sync     (hsync)
  );

  vga_axis_timer #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v_timer (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_v_step),
    .o_count    (CounterY),
    .o_count_nxt(w_y_nxt),
    .o_phase    (w_v_phase),
    .o_wrap     (w_v_wrap),
    .o_sync     (vsync)
  );

  // Wrap pulses mark exactly the edges where X (and Y) become 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_in_display  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + 1'b1;
      if (w_pix_en) begin
        r_in_display  <= (w_x_nxt < CNT_W'(H_ACTIVE)) && (w_y_nxt < CNT_W'(V_ACTIVE));
        r_line_start  <= w_h_wrap;
        r_frame_start <= w_v_wrap;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    in_display == ((w_h_phase == PH_ACT) && (w_v_phase == PH_ACT)));

  assign pix_en      = w_pix_en;
  assign in_display  = r_in_display;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed checks: default 640x480 timing at CLK_DIV=4, and a shrunken raster at CLK_DIV=1, SYNC_POL=1.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       a_pix_en, a_hs, a_vs, a_disp, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pix_en, b_hs, b_vs, b_disp, b_ls, b_fs;
  logic [9:0] b_x, b_y;

  int total = 0;
  int bad   = 0;

  vga_sync_gen u_dut_a (
    .clk(clk), .reset(rst_a), .pix_en(a_pix_en), .CounterX(a_x), .CounterY(a_y),
    .hsync(a_hs), .vsync(a_vs), .in_display(a_disp), .line_start(a_ls), .frame_start(a_fs)
  );

  // Small raster: H 8/2/3/2 = 15 pixels (sync X 10..12), V 4/1/2/1 = 8 lines (sync Y 5..6).
  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .pix_en(b_pix_en), .CounterX(b_x), .CounterY(b_y),
    .hsync(b_hs), .vsync(b_vs), .in_display(b_disp), .line_start(b_ls), .frame_start(b_fs)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int errs, disp_clks, hs_clks, vs_clks, fs_clks, run, hs_first, hs_last, vs_x, vs_y;
    logic [9:0] prev_x;
    logic found;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    check_val("a_rst_x",  32'(a_x), 32'd799);
    check_val("a_rst_y",  32'(a_y), 32'd524);
    check_val("a_rst_hs", 32'(a_hs), 32'd1);
    check_val("a_rst_vs", 32'(a_vs), 32'd1);
    check_val("a_rst_flags", {29'd0, a_disp, a_ls, a_fs}, 32'd0);
    check_val("a_rst_pix_en", 32'(a_pix_en), 32'd0);
    check_val("b_rst_xy", {6'd0, b_x, 6'd0, b_y}, {6'd0, 10'd14, 6'd0, 10'd7});
    check_val("b_rst_sync", {30'd0, b_hs, b_vs}, 32'd0);

    // First pixel after release, CLK_DIV=4.
    rst_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val($sformatf("a_pix_en_e%0d", k), 32'(a_pix_en), 32'((k % 4) == 3));
      if (k == 3) check_val("a_x_before_first", 32'(a_x), 32'd799);
    end
    check_val("a_first_xy", {6'd0, a_x, 6'd0, a_y}, 32'd0);
    check_val("a_first_flags", {29'd0, a_disp, a_ls, a_fs}, 32'd7);
    check_val("a_first_hs", 32'(a_hs), 32'd1);

    // One full line of line 0, sampled every clock.
    errs = 0; disp_clks = 0; hs_clks = 0; fs_clks = 0; run = 0;
    hs_first = -1; hs_last = -1; prev_x = '0;
    for (int i = 0; i < 3200; i++) begin
      if (a_pix_en !== ((i % 4) == 3)) errs++;
      if (a_hs !== !(a_x >= 10'd656 && a_x < 10'd752)) errs++;
      if (a_disp !== (a_x < 10'd640)) errs++;
      if (a_ls !== (a_x == 10'd0)) errs++;
      if (a_vs !== 1'b1) errs++;
      if (a_disp) disp_clks++;
      if (a_fs) fs_clks++;
      if (!a_hs) begin
        hs_clks++;
        if (hs_first < 0) hs_first = int'(a_x);
        hs_last = int'(a_x);
      end
      if (i > 0 && a_x != prev_x) begin
        if (run != 4) errs++;
        run = 1;
      end else begin
        run++;
      end
      prev_x = a_x;
      if (i == 4) check_val("a_second_pixel", {6'd0, a_x, 15'd0, a_fs}, {6'd0, 10'd1, 16'd0});
      @(negedge clk);
    end
    check_val("a_line_model_errs", 32'(errs), 32'd0);
    check_val("a_disp_clks", 32'(disp_clks), 32'd2560);
    check_val("a_hs_low_clks", 32'(hs_clks), 32'd384);
    check_val("a_hs_first_x", 32'(hs_first), 32'd656);
    check_val("a_hs_last_x", 32'(hs_last), 32'd751);
    check_val("a_fs_clks", 32'(fs_clks), 32'd4);
    check_val("a_line_end_xy", {6'd0, a_x, 6'd0, a_y}, {6'd0, 10'd0, 6'd0, 10'd1});
    check_val("a_line_end_ls_fs", {30'd0, a_ls, a_fs}, 32'd2);

    // Asynchronous reset mid-line at X=300.
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      if (a_x == 10'd300) found = 1'b1;
      else @(negedge clk);
    end
    check_val("a_wait_x300", 32'(found), 32'd1);
    rst_a = 1'b1;
    #1;
    check_val("a_midrst_xy", {6'd0, a_x, 6'd0, a_y}, {6'd0, 10'd799, 6'd0, 10'd524});
    check_val("a_midrst_out", {27'd0, a_hs, a_vs, a_disp, a_ls, a_fs}, 32'b11000);
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_hs !== 1'b1 || a_vs !== 1'b1 || a_x !== 10'd799) errs++;
    end
    rst_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4 && (a_x !== 10'd799 || a_hs !== 1'b1 || a_vs !== 1'b1)) errs++;
    end
    check_val("a_midrst_hold_errs", 32'(errs), 32'd0);
    check_val("a_restart_xy", {6'd0, a_x, 6'd0, a_y}, 32'd0);
    check_val("a_restart_fs", 32'(a_fs), 32'd1);

    // Small raster, CLK_DIV=1, active-high syncs: one full frame.
    rst_b = 1'b0;
    @(negedge clk);
    check_val("b_first_xy", {6'd0, b_x, 6'd0, b_y}, 32'd0);
    check_val("b_first_flags", {29'd0, b_disp, b_ls, b_fs}, 32'd7);
    errs = 0; disp_clks = 0; hs_clks = 0; vs_clks = 0; fs_clks = 0; vs_x = -1; vs_y = -1;
    for (int i = 0; i < 120; i++) begin
      if (b_pix_en !== 1'b1) errs++;
      if (b_hs !== (b_x >= 10'd10 && b_x <= 10'd12)) errs++;
      if (b_vs !== (b_y >= 10'd5 && b_y <= 10'd6)) errs++;
      if (b_disp !== (b_x < 10'd8 && b_y < 10'd4)) errs++;
      if (b_hs) hs_clks++;
      if (b_disp) disp_clks++;
      if (b_fs) fs_clks++;
      if (b_vs) begin
        vs_clks++;
        if (vs_x < 0) begin
          vs_x = int'(b_x);
          vs_y = int'(b_y);
        end
      end
      if (i == 119) check_val("b_last_xy", {6'd0, b_x, 6'd0, b_y}, {6'd0, 10'd14, 6'd0, 10'd7});
      @(negedge clk);
    end
    check_val("b_frame_model_errs", 32'(errs), 32'd0);
    check_val("b_hs_high_clks", 32'(hs_clks), 32'd24);
    check_val("b_vs_high_clks", 32'(vs_clks), 32'd30);
    check_val("b_vs_start", {16'(vs_x), 16'(vs_y)}, {16'd0, 16'd5});
    check_val("b_disp_clks", 32'(disp_clks), 32'd32);
    check_val("b_fs_clks", 32'(fs_clks), 32'd1);
    check_val("b_wrap_xy", {6'd0, b_x, 6'd0, b_y}, 32'd0);
    check_val("b_wrap_fs", 32'(b_fs), 32'd1);

    // Asynchronous reset mid-frame at (3,2).
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      if (b_x == 10'd3 && b_y == 10'd2) found = 1'b1;
      else @(negedge clk);
    end
    check_val("b_wait_3_2", 32'(found), 32'd1);
    rst_b = 1'b1;
    #1;
    check_val("b_midrst_xy", {6'd0, b_x, 6'd0, b_y}, {6'd0, 10'd14, 6'd0, 10'd7});
    check_val("b_midrst_out", {27'd0, b_hs, b_vs, b_disp, b_ls, b_fs}, 32'd0);
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (b_hs !== 1'b0 || b_vs !== 1'b0) errs++;
    end
    check_val("b_midrst_hold_errs", 32'(errs), 32'd0);
    rst_b = 1'b0;
    @(negedge clk);
    check_val("b_restart_xy", {6'd0, b_x, 6'd0, b_y}, 32'd0);
    check_val("b_restart_fs", 32'(b_fs), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
